// File: rtl/bus_memory_responder.sv
// bus_memory_responder
//
// Memory-side responder for the cache/memory bus. It accepts line-granular
// read and write requests, stores lines in an internal word array and
// returns read data as a burst of BEATS response beats.
//
// Handshake summary:
//   Request side: a beat is taken at a rising edge where bus_reqcyc=1 and
//   bus_reqack=0. bus_reqack is registered and pulses for exactly the
//   following cycle. A bus_reqcyc held through the ack cycle is therefore
//   never mistaken for a new beat. Requests are only taken in IDLE (address
//   beat) and WDATA (write data beats). In any other state the initiator
//   holds bus_reqcyc until the block is back in IDLE.
//   Response side: bus_respcyc=1 presents a beat on bus_resp. The beat is
//   consumed at an edge where bus_respack=1, and the next beat appears in the
//   following cycle. bus_respack is ignored outside RESP.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus_reqcyc   request beat valid
//   bus_reqack   one-cycle ack per accepted request beat
//   bus_req      byte address (first beat) / write data (later beats)
//   bus_reqtag   request tag, sampled on the address beat
//   bus_respcyc  response beat valid
//   bus_respack  initiator accepts the current response beat
//   bus_resp     response data
//   bus_resptag  READ_TAG while bus_respcyc is high, else 0
//   busy         high whenever the FSM is not in IDLE
//   dbg_state    current FSM state (0 IDLE, 1 WDATA, 2 WAIT, 3 RESP)

`ifndef MEM_READ
`define MEM_READ 13'h0001
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 13'h0002
`endif

module bus_memory_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG  = `MEM_READ,
    parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG = `MEM_WRITE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [AW-1:0]       base_q;
    logic [IW-1:0]       idx_q;
    logic [CW-1:0]       cnt_q;

    // Backing store. Deliberately outside the reset domain: a reset abandons
    // the burst but keeps whatever has already been written.
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic          beat_accept;
    logic [AW-1:0] req_base;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] next_rd_addr;

    // The ack register masks the beat that is still being held during the
    // ack cycle.
    assign beat_accept = bus_reqcyc && !bus_reqack;

    // Line number (byte address / 64) scaled to a word index. Bits above the
    // array depth fall off, so addresses alias rather than fault.
    assign req_base = AW'(bus_req >> 6) << IW;

    assign wr_addr      = base_q + AW'(idx_q);
    assign next_rd_addr = base_q + AW'(idx_q + IW'(1));

    assign busy        = (state != S_IDLE);
    assign bus_resptag = bus_respcyc ? READ_TAG : '0;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            bus_reqack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (beat_accept) begin
                        bus_reqack <= 1'b1;
                        base_q     <= req_base;
                        idx_q      <= '0;
                        if (bus_reqtag == READ_TAG) begin
                            state <= S_WAIT;
                            cnt_q <= CW'(READ_LATENCY);
                        end else if (bus_reqtag == WRITE_TAG) begin
                            state <= S_WDATA;
                        end
                        // Unknown tags are acked and dropped.
                    end
                end
                S_WDATA: begin
                    if (beat_accept) begin
                        bus_reqack <= 1'b1;
                        idx_q      <= idx_q + IW'(1);
                        if (idx_q == LAST_BEAT) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state       <= S_RESP;
                        idx_q       <= '0;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem[base_q];
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_RESP: begin
                    if (bus_respack) begin
                        if (idx_q == LAST_BEAT) begin
                            state       <= S_IDLE;
                            bus_respcyc <= 1'b0;
                            bus_resp    <= '0;
                        end else begin
                            idx_q    <= idx_q + IW'(1);
                            bus_resp <= mem[next_rd_addr];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WDATA && beat_accept) begin
            mem[wr_addr] <= bus_req;
        end
    end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed testbench for bus_memory_responder. Two instances share the same
// stimulus: u_big uses the default array depth, u_small uses 16 words so
// that line aliasing is visible.
module tb_bus_memory_responder;

    localparam logic [12:0] RD  = 13'h0001;
    localparam logic [12:0] WR  = 13'h0002;
    localparam int          LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqcyc;
    logic        respack;
    logic [63:0] req;
    logic [12:0] reqtag;

    logic        ack_a, respcyc_a, busy_a;
    logic [63:0] resp_a;
    logic [12:0] resptag_a;
    logic [1:0]  dbg_a;
    logic        ack_b, respcyc_b, busy_b;
    logic [63:0] resp_b;
    logic [12:0] resptag_b;
    logic [1:0]  dbg_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] got_a [8];
    logic [63:0] got_b [8];
    logic [63:0] exp_a_q [$];
    logic [63:0] exp_b_q [$];
    int          beats, first_cyc, acks_seen, ack_cyc;
    bit          tag_ok, hold_ok, sync_ok;

    bus_memory_responder #(
        .MEM_WORDS(4096), .READ_LATENCY(LAT), .READ_TAG(RD), .WRITE_TAG(WR)
    ) u_big (
        .clk(clk), .reset(reset),
        .bus_reqcyc(reqcyc), .bus_reqack(ack_a), .bus_req(req), .bus_reqtag(reqtag),
        .bus_respcyc(respcyc_a), .bus_respack(respack), .bus_resp(resp_a),
        .bus_resptag(resptag_a), .busy(busy_a), .dbg_state(dbg_a)
    );

    bus_memory_responder #(
        .MEM_WORDS(16), .READ_LATENCY(LAT), .READ_TAG(RD), .WRITE_TAG(WR)
    ) u_small (
        .clk(clk), .reset(reset),
        .bus_reqcyc(reqcyc), .bus_reqack(ack_b), .bus_req(req), .bus_reqtag(reqtag),
        .bus_respcyc(respcyc_b), .bus_respack(respack), .bus_resp(resp_b),
        .bus_resptag(resptag_b), .busy(busy_b), .dbg_state(dbg_b)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Driver: present one request beat and hold it until acked (bounded).
    task automatic send_req(input string name, input logic [63:0] d, input logic [12:0] t);
        int  g;
        bit  got;
        req    = d;
        reqtag = t;
        reqcyc = 1'b1;
        got    = 1'b0;
        g      = 0;
        while (!got && g < 200) begin
            tick();
            g++;
            if (ack_a === 1'b1) got = 1'b1;
        end
        check({name, "_acked"}, 64'(got), 64'd1);
        check({name, "_ack_sync"}, 64'(ack_b), 64'(ack_a));
        ack_cyc = cyc;
        reqcyc  = 1'b0;
    endtask

    task automatic write_line(input string name, input logic [63:0] addr, input logic [63:0] d0);
        send_req({name, "_addr"}, addr, WR);
        check({name, "_busy"}, 64'(busy_a), 64'd1);
        for (int i = 0; i < 8; i++) begin
            send_req({name, "_data"}, d0 + 64'(i), WR);
        end
        check({name, "_idle_after"}, 64'(busy_a), 64'd0);
    endtask

    // Monitor: wait for the burst, then consume beats. mode 0 acks every
    // cycle, mode 1 acks with the pattern 1,0,0,1,0,0...
    task automatic collect(input int mode);
        int          n, guard, step;
        logic [63:0] prev_a;
        logic        acked;
        n = 0; guard = 0; step = 0;
        tag_ok = 1'b1; hold_ok = 1'b1; sync_ok = 1'b1;
        while (respcyc_a !== 1'b1 && guard < 100) begin
            if (ack_a === 1'b1) acks_seen++;
            tick();
            guard++;
        end
        first_cyc = cyc;
        while (respcyc_a === 1'b1 && n < 8 && guard < 300) begin
            if (resptag_a !== RD || resptag_b !== RD) tag_ok = 1'b0;
            if (respcyc_b !== 1'b1) sync_ok = 1'b0;
            acked   = (mode == 0) ? 1'b1 : ((step % 3) == 0);
            respack = acked;
            step++;
            prev_a = resp_a;
            if (acked) begin
                got_a[n] = resp_a;
                got_b[n] = resp_b;
                n++;
            end
            if (ack_a === 1'b1) acks_seen++;
            tick();
            guard++;
            if (!acked && resp_a !== prev_a) hold_ok = 1'b0;
        end
        respack = 1'b0;
        beats   = n;
    endtask

    // Scoreboard: expected beats are queued and popped against the capture.
    task automatic compare_burst(input string name, input logic [63:0] a0, input logic [63:0] b0);
        logic [63:0] e;
        for (int i = 0; i < 8; i++) begin
            exp_a_q.push_back(a0 + 64'(i));
            exp_b_q.push_back(b0 + 64'(i));
        end
        check({name, "_beats"}, 64'(beats), 64'd8);
        check({name, "_respcyc_low"}, 64'(respcyc_a), 64'd0);
        check({name, "_idle"}, 64'(busy_a), 64'd0);
        check({name, "_tag"}, 64'(tag_ok), 64'd1);
        check({name, "_hold"}, 64'(hold_ok), 64'd1);
        check({name, "_sync"}, 64'(sync_ok), 64'd1);
        for (int i = 0; i < beats; i++) begin
            e = exp_a_q.pop_front();
            check({name, "_big_data"}, got_a[i], e);
            e = exp_b_q.pop_front();
            check({name, "_small_data"}, got_b[i], e);
        end
        exp_a_q.delete();
        exp_b_q.delete();
    endtask

    initial begin
        int acks, bad, g;

        reset   = 1'b0;
        reqcyc  = 1'b0;
        respack = 1'b0;
        req     = '0;
        reqtag  = '0;

        // Reset values
        #12;
        check("rst_reqack", 64'(ack_a), 64'd0);
        check("rst_respcyc", 64'(respcyc_a), 64'd0);
        check("rst_resp", resp_a, 64'd0);
        check("rst_resptag", 64'(resptag_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        #5 reset = 1'b1;
        tick();

        // Write then read, with latency check
        write_line("wr1040", 64'h1040, 64'hA0);
        send_req("rd1040", 64'h1040, RD);
        check("rd1040_busy", 64'(busy_a), 64'd1);
        acks_seen = 0;
        collect(0);
        check("rd1040_latency", 64'(first_cyc - ack_cyc), 64'(LAT + 1));
        compare_burst("rd1040", 64'hA0, 64'hA0);

        // Unaligned address in the same line, with response backpressure
        send_req("rd107f", 64'h107F, RD);
        collect(1);
        compare_burst("rd107f_bp", 64'hA0, 64'hA0);

        // Address wrap: 0x80 is word 16, aliasing word 0 in the 16-word array
        write_line("wr0000", 64'h0, 64'hC0);
        write_line("wr0080", 64'h80, 64'hB0);
        send_req("rd0000", 64'h0, RD);
        collect(0);
        compare_burst("rd0000_wrap", 64'hC0, 64'hB0);
        send_req("rd0080", 64'h80, RD);
        collect(0);
        compare_burst("rd0080", 64'hB0, 64'hB0);

        // Held reqcyc gives one ack; a second read during WAIT waits its turn
        req    = 64'h1040;
        reqtag = RD;
        reqcyc = 1'b1;
        acks   = 0;
        repeat (3) begin
            tick();
            if (ack_a === 1'b1) acks++;
        end
        check("held_one_ack", 64'(acks), 64'd1);
        check("held_busy", 64'(busy_a), 64'd1);
        req       = 64'h0;
        acks_seen = 0;
        collect(0);
        check("busy_reject_no_ack", 64'(acks_seen), 64'd0);
        compare_burst("held_first", 64'hA0, 64'hA0);
        g = 0;
        while (ack_a !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        check("second_ack_first_idle_edge", 64'(g), 64'd1);
        reqcyc = 1'b0;
        collect(0);
        compare_burst("held_second", 64'hC0, 64'hB0);

        // Unknown tag: acked, then ignored
        send_req("unk", 64'h1040, 13'h0000);
        check("unk_busy", 64'(busy_a), 64'd0);
        bad = 0;
        repeat (20) begin
            tick();
            if (respcyc_a !== 1'b0 || busy_a !== 1'b0 || respcyc_b !== 1'b0) bad++;
        end
        check("unk_no_resp", 64'(bad), 64'd0);

        // Asynchronous reset in the middle of a response burst
        send_req("rst_rd", 64'h1040, RD);
        g = 0;
        while (respcyc_a !== 1'b1 && g < 50) begin
            tick();
            g++;
        end
        check("rst_rd_in_resp", 64'(respcyc_a), 64'd1);
        tick();
        #3 reset = 1'b0;
        #1;
        check("async_reqack", 64'(ack_a), 64'd0);
        check("async_respcyc", 64'(respcyc_a), 64'd0);
        check("async_resp", resp_a, 64'd0);
        check("async_resptag", 64'(resptag_a), 64'd0);
        check("async_busy", 64'(busy_a), 64'd0);
        #2 reset = 1'b1;
        tick();
        check("post_rst_busy", 64'(busy_a), 64'd0);
        send_req("post_rst_rd", 64'h1040, RD);
        collect(0);
        compare_burst("post_rst_rd", 64'hA0, 64'hA0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
